// File: rtl/ex_alu_stage.sv
// ============================================================================
// ex_alu_stage
// ----------------------------------------------------------------------------
// Execute-stage ALU for the pipelined 32-bit MIPS core.
//
// Consumes the 4-bit ALU control code from the decode-side ALU control logic
// plus operands and destination tag, computes add/sub/and/or/slt
// combinationally and registers the result into the EX/MEM boundary.
//
// A valid/ready handshake on both sides uses a two-slot store:
//   - MAIN drives the outputs.
//   - SKID catches the one op that arrives in the same cycle MAIN stalls.
// in_ready depends only on registered state, so the memory stage's stall
// never forms a combinational path back into decode.
//
// Optional feature (compile-time macro ALU_OVF_TRAP_EN):
//   defined   - signed overflow on add/sub raises out_ovf and suppresses
//               out_regwrite; out_result still carries the wrapped value.
//   undefined - out_ovf is tied 0 and overflowed results are written normally.
//
// Parameters:
//   WIDTH          operand/result width
//   CNT_W          width of the saturating illegal-op counter
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   flush          synchronous pipeline flush (drops both slots and the input)
//   in_valid       upstream op valid
//   in_ready       stage can accept an op
//   in_alucontrol  ALU control code
//   in_a, in_b     operands (rs, rt/immediate)
//   in_rd          destination register
//   in_regwrite    op writes the register file
//   out_valid      result valid
//   out_ready      MEM stage accepts
//   out_result     ALU result
//   out_zero       result == 0
//   out_rd         destination register
//   out_regwrite   final write enable
//   out_illegal    control code was not recognised
//   out_ovf        signed overflow trap
//   illegal_count  saturating count of accepted illegal ops
// ============================================================================
module ex_alu_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_alucontrol,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [4:0]       in_rd,
    input  logic             in_regwrite,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic [4:0]       out_rd,
    output logic             out_regwrite,
    output logic             out_illegal,
    output logic             out_ovf,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // One pipeline entry: everything that crosses EX/MEM for a single op.
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic [4:0]       rd;
        logic             regwrite;
        logic             illegal;
        logic             ovf;
    } entry_t;

    // ------------------------------------------------------------------------
    // Combinational ALU on the input side
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] and_vec;
    logic [WIDTH-1:0] or_vec;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             slt_bit;
    logic [WIDTH-1:0] alu_result;
    logic             alu_legal;
    logic             alu_ovf;
    entry_t           in_entry;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_logic_bits
            assign and_vec[gi] = in_a[gi] & in_b[gi];
            assign or_vec[gi]  = in_a[gi] | in_b[gi];
        end
    endgenerate

    assign sum  = in_a + in_b;
    assign diff = in_a - in_b;

    // Signed less-than without trusting the subtraction sign when it can
    // overflow: if the signs differ, A is smaller exactly when A is negative;
    // if they match, the difference cannot overflow and its sign is exact.
    assign slt_bit = (in_a[WIDTH-1] != in_b[WIDTH-1]) ? in_a[WIDTH-1]
                                                      : diff[WIDTH-1];

    always_comb begin
        alu_result = '0;
        alu_legal  = 1'b1;
        alu_ovf    = 1'b0;
        case (in_alucontrol)
            ALU_ADD: begin
                alu_result = sum;
`ifdef ALU_OVF_TRAP_EN
                // Same-sign operands producing an opposite-sign sum.
                alu_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                          (sum[WIDTH-1] != in_a[WIDTH-1]);
`endif
            end
            ALU_SUB: begin
                alu_result = diff;
`ifdef ALU_OVF_TRAP_EN
                // Opposite-sign operands where the result takes B's sign.
                alu_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                          (diff[WIDTH-1] != in_a[WIDTH-1]);
`endif
            end
            ALU_AND: alu_result = and_vec;
            ALU_OR:  alu_result = or_vec;
            ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, slt_bit};
            default: begin
                alu_result = '0;
                alu_legal  = 1'b0;
            end
        endcase
    end

    always_comb begin
        in_entry.result   = alu_result;
        in_entry.zero     = (alu_result == '0);
        in_entry.rd       = in_rd;
        in_entry.regwrite = in_regwrite & alu_legal & ~alu_ovf;
        in_entry.illegal  = ~alu_legal;
        in_entry.ovf      = alu_ovf;
    end

    // ------------------------------------------------------------------------
    // MAIN / SKID storage and handshake
    // ------------------------------------------------------------------------
    entry_t           main_reg,  main_next;
    entry_t           skid_reg,  skid_next;
    logic             main_valid_reg, main_valid_next;
    logic             skid_valid_reg, skid_valid_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic             accept;
    logic             pop;

    // Ready comes from registered state only; reset holds it low.
    assign in_ready = rst_n & ~skid_valid_reg;
    assign accept   = in_valid & in_ready & ~flush;
    assign pop      = main_valid_reg & out_ready;

    always_comb begin
        main_next       = main_reg;
        skid_next       = skid_reg;
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        cnt_next        = cnt_reg;

        if (flush) begin
            // Flush drops both slots and the op on the input this cycle; the
            // counter is left alone because nothing was accepted.
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else begin
            if (!main_valid_reg || pop) begin
                if (skid_valid_reg) begin
                    // Oldest entry lives in SKID: it moves up first.
                    main_next       = skid_reg;
                    main_valid_next = 1'b1;
                    // in_ready is low while SKID holds data, so nothing can be
                    // accepted alongside this move; the branch keeps ordering
                    // explicit should that ever change.
                    skid_valid_next = accept;
                    if (accept) begin
                        skid_next = in_entry;
                    end
                end else if (accept) begin
                    main_next       = in_entry;
                    main_valid_next = 1'b1;
                    skid_valid_next = 1'b0;
                end else begin
                    main_valid_next = 1'b0;
                    skid_valid_next = 1'b0;
                end
            end else if (accept) begin
                // MAIN is stalled: absorb this op in SKID.
                skid_next       = in_entry;
                skid_valid_next = 1'b1;
            end

            if (accept && in_entry.illegal && (cnt_reg != CNT_MAX)) begin
                cnt_next = cnt_reg + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            main_reg       <= main_next;
            skid_reg       <= skid_next;
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            cnt_reg        <= cnt_next;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs straight from MAIN
    // ------------------------------------------------------------------------
    assign out_valid     = main_valid_reg;
    assign out_result    = main_reg.result;
    assign out_zero      = main_reg.zero;
    assign out_rd        = main_reg.rd;
    assign out_regwrite  = main_reg.regwrite;
    assign out_illegal   = main_reg.illegal;
    assign out_ovf       = main_reg.ovf;
    assign illegal_count = cnt_reg;

endmodule

// File: doc/ex_alu_stage.md
# ex_alu_stage

Execute-stage ALU for the pipelined 32-bit MIPS core. It consumes the 4-bit ALU control code produced by the decode-side ALU control logic, together with operands and destination tag. It computes add/sub/and/or/slt and registers the result into the EX/MEM boundary. A valid/ready handshake on both sides and a one-entry skid buffer let the memory stage stall without combinational ready paths back into decode.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width
- `CNT_W`, 8, width of the saturating illegal-op counter

Ports:
- `clk` input 1 — rising-edge clock.
- `rst_n` input 1 — asynchronous active-low reset.
- `flush` input 1 — synchronous pipeline flush.
- `in_valid` input 1 — upstream op valid.
- `in_ready` output 1 — stage can accept an op.
- `in_alucontrol` input 4 — ALU control code.
- `in_a` input WIDTH — operand A (rs).
- `in_b` input WIDTH — operand B (rt or immediate).
- `in_rd` input 5 — destination register.
- `in_regwrite` input 1 — op writes the register file.
- `out_valid` output 1 — result valid.
- `out_ready` input 1 — MEM stage accepts.
- `out_result` output WIDTH — ALU result.
- `out_zero` output 1 — result == 0.
- `out_rd` output 5 — destination register.
- `out_regwrite` output 1 — final write enable.
- `out_illegal` output 1 — code was not recognised.
- `out_ovf` output 1 — signed overflow trap.
- `illegal_count` output CNT_W — saturating count of accepted illegal ops.

## Operation
- **Codes:**
  - 0010: `a + b`.
  - 0110: `a - b`.
  - 0000: `a & b`.
  - 0001: `a | b`.
  - 0111: slt, signed; result 1 if `a < b`, else 0; the comparison is immune to subtraction overflow.
  - Arithmetic is modulo 2^WIDTH.
- **Any other code:** result 0, `out_illegal`=1, `out_regwrite` forced 0. `illegal_count` increments once per accepted illegal op and saturates at 2^CNT_W−1.
- **Computation:** the ALU is combinational on the input side. Result, zero, rd, regwrite, illegal and ovf are captured together as one entry at acceptance.
- **Storage:** two entry slots, MAIN (drives the outputs) and SKID.
- **Handshake signals:**
  - `in_ready` = `rst_n` & !SKID.valid, from registered state only.
  - Accept = `in_valid` & `in_ready` & !`flush`.
  - Pop = `out_valid` & `out_ready`.
- **Slot update per cycle:**
  - MAIN empty or popping: MAIN ← SKID if SKID is valid, otherwise ← the accepted input, otherwise empty. SKID ← accepted input only if it was valid before and MAIN took it; otherwise SKID ← empty.
  - MAIN valid and not popping: an accepted input goes to SKID.
- **Ordering:** strictly preserved; no entry is lost or duplicated.
- **`flush`:** priority over everything. It clears MAIN.valid and SKID.valid on that edge. The input in that cycle is discarded and not counted. `illegal_count` is unaffected.

## Timing
- **Reset (`rst_n` low, asynchronous):** `out_valid`=0, `in_ready`=0. `out_result`, `out_zero`, `out_rd`, `out_regwrite`, `out_illegal`, `out_ovf` and `illegal_count` are all 0. SKID is empty.
- **After reset:** `in_ready`=1 from the first cycle after deassertion.
- **Latency:** 1 cycle. An op accepted at edge N is visible on the outputs after edge N, provided MAIN was empty or popping.
- **Throughput:** 1 op/cycle while `out_ready`=1.
- **Backpressure:**
  - `out_ready`=0 with MAIN full: one further op is absorbed into SKID, then `in_ready` drops on the next cycle.
  - `in_ready` returns to 1 the cycle after SKID drains.
- **Outputs:** stable while `out_valid`=1 and `out_ready`=0.
- **Reset mid-operation:** both entries are dropped immediately.

## Configuration
- **`ALU_OVF_TRAP_EN` defined:**
  - Signed overflow on add (0010) or sub (0110) sets `out_ovf`=1 and forces `out_regwrite`=0.
  - `out_result` still carries the wrapped value.
  - slt/and/or never set `out_ovf`.
- **Not defined:** `out_ovf` is tied 0, and overflowed results are written normally.

## Test plan
- **Reset/basic:** after reset, send add a=5 b=7 rd=3 regwrite=1, `out_ready`=1 → next cycle `out_valid`=1, result=12, zero=0, rd=3, regwrite=1.
- **slt/sub:**
  - slt a=0x80000000, b=1 → result 1.
  - sub a=9, b=9 → result 0, zero=1.
  - and 0xF0F0&0x0FF0 → 0x00F0.
  - or → 0xFFF0.
- **Backpressure:** hold `out_ready`=0 and stream ops 1,2,3.
  - Op1 in MAIN, op2 in SKID, `in_ready`=0; op3 held.
  - Release → ops pop in order 1,2,3 with no loss or duplicates.
- **Illegal:** code 1111 with regwrite=1 → result 0, illegal=1, regwrite=0, count=1. 300 illegal ops with CNT_W=8 → count 255.
- **Overflow, with the macro defined:** add 0x7FFFFFFF+1 → result 0x80000000, ovf=1, regwrite=0. Without the macro: ovf=0, regwrite=1.
- **Flush/reset:**
  - MAIN and SKID full, assert `flush` together with `in_valid` → next cycle `out_valid`=0, `in_ready`=1, count unchanged.
  - Asserting `rst_n` low mid-stream → outputs 0 immediately.
